// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shift/rotate engine: one bit position per clock, result
// presented with a single-cycle done pulse.
module shift_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [2:0] OpShr  = 3'b000;
  localparam logic [2:0] OpShra = 3'b001;
  localparam logic [2:0] OpShl  = 3'b010;
  localparam logic [2:0] OpRor  = 3'b011;
  localparam logic [2:0] OpRol  = 3'b100;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  opr_q, opr_d;
  logic [31:0] result_q, result_d;
  logic [31:0] acc_step;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      opr_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      opr_q    <= opr_d;
      result_q <= result_d;
    end
  end

  // Unused opcodes hold acc so latency matches a real operation.
  always_comb begin
    acc_step = acc_q;
    case (opr_q)
      OpShr:   acc_step = {1'b0, acc_q[31:1]};
      OpShra:  acc_step = {acc_q[31], acc_q[31:1]};
      OpShl:   acc_step = {acc_q[30:0], 1'b0};
      OpRor:   acc_step = {acc_q[0], acc_q[31:1]};
      OpRol:   acc_step = {acc_q[30:0], acc_q[31]};
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    opr_d    = opr_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          acc_d   = a;
          cnt_d   = b[4:0];
          opr_d   = op;
        end
      end
      StShift: begin
        if (cnt_q != 5'd0) begin
          acc_d = acc_step;
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d  = StDone;
          result_d = acc_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    result = result_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer: latency, results, lockout,
// abort and reset behaviour against hand-computed values.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  shift_sequencer dut (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue a request, scramble inputs after the start edge, then measure the
  // number of edges from E0 until done and check the result and the return to idle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp, input int lat);
    int k;
    int idle_seen;
    @(negedge clock);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    k = 0;
    idle_seen = 0;
    while (!done && k < 40) begin
      if (!busy) idle_seen++;
      @(posedge clock);
      #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check({tag, "_busy"}, 32'(idle_seen), 32'd0);
    check({tag, "_res"}, result, exp);
    @(posedge clock);
    #1;
    check({tag, "_end"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int k;
    int pulses;
    clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    check("rst_flags", {30'd0, busy, done}, 32'd0);
    check("rst_result", result, 32'h0);

    run_op("rol4", 3'b100, 32'h8000_0001, 32'd4, 32'h0000_0018, 5);
    run_op("shra31", 3'b001, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_op("shr31", 3'b000, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_op("shr31_ones", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);
    run_op("shra_pos", 3'b001, 32'h4000_0000, 32'd3, 32'h0800_0000, 4);
    run_op("ror0", 3'b011, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run_op("ror_wrap", 3'b011, 32'h0000_0001, 32'h0000_0021, 32'h8000_0000, 2);
    run_op("noop", 3'b110, 32'hDEAD_BEEF, 32'd5, 32'hDEAD_BEEF, 6);

    // Busy lockout: SHL by 8 with a stray start at E3 and another in the done cycle.
    @(negedge clock);
    op = 3'b010; a = 32'hFFFF_FFFF; b = 32'd8; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    op = 3'b000; a = 32'h0; b = 32'd1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    k = 3;
    while (!done && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("lock_lat", 32'(k), 32'd9);
    check("lock_res", result, 32'hFFFF_FF00);
    op = 3'b000; a = 32'h0000_1234; b = 32'd2; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("lock_done_ignored", {30'd0, busy, done}, 32'd0);
    check("lock_hold", result, 32'hFFFF_FF00);
    run_op("b2b", 3'b000, 32'h0000_1234, 32'd2, 32'h0000_048D, 3);

    // Abort: ROR by 10, clear at E4.
    @(negedge clock);
    op = 3'b011; a = 32'hA5A5_0F0F; b = 32'd10; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check("abort_flags", {30'd0, busy, done}, 32'd0);
    check("abort_result", result, 32'h0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) pulses++;
    end
    check("abort_quiet", 32'(pulses), 32'd0);
    run_op("post_abort", 3'b100, 32'h0000_0001, 32'd31, 32'h8000_0000, 32);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
